miner_csr_mc: RTL and testbench
===============================

# miner_csr_mc

Avalon-MM slave register block for a multi-core SHA3-256 mining array, parametrised in core count, nonce width and solution-queue depth. It splits the nonce space across cores, running all cores in the host clock domain; the PLL and core instances sit outside this block. Solutions from all cores are queued in a FIFO with overflow detection and a maskable level IRQ.

## Interface
- CORES, 4: number of mining cores, 1–8
- NONCE_W, 64: nonce width, 64 or 128
- FIFO_DEPTH, 8: solution FIFO entries, power of 2, 2–16
- STAGES, 8: core pipeline depth, reported in STAT
- MAJ_VER, 0 / MIN_VER, 0: 4-bit version fields
- clk  in  1  host clock, also drives the cores
- rst_n  in  1  reset, asynchronous, active-low
- address  in  6  word address
- read / write  in  1  Avalon strobes
- writedata  in  32  write data
- readdata  out  32  registered read data, 1-cycle latency
- irq  out  1  level interrupt, active high
- core_header / core_difficulty  out  256  shared job data (HDR / DIFF words, word 0 = MS)
- core_pad  out  16  CTL[31:16]
- core_test / core_halt  out  1  CTL[1] / CTL[2]
- core_run  out  CORES  per-core run
- core_start_nonce  out  CORES*NONCE_W  per-core start nonce, core i at slice i
- core_found  in  CORES  single-cycle solution pulse
- core_solution  in  CORES*NONCE_W  nonce, valid with core_found

## Operation
- Word map:
  - 0 ID: RO "SHA3".
  - 1 STAT: RO. [0] FIFO non-empty, [1] state==RUN, [2] test, [3] overflow, [7:4] STAGES, [11:8] CORES, [16:12] FIFO level, [27:24] MAJ_VER, [31:28] MIN_VER.
  - 2 CTL: RW. [0] run, [1] test, [2] halt, [31:16] pad.
  - 3 IRQ: [0] enable RW; [1] pending, W1C; [2] overflow, W1C.
  - 4–11 HDR, 12–19 DIFF.
  - 20–23 START, 24–27 STRIDE: NONCE_W/32 words, MS first; unused words read 0.
  - 32–35 SOLN head nonce: RO, MS first.
  - 36 SOLN_CORE: RO. [2:0] core id, [31] valid. Any write to 36 pops the FIFO; a pop when empty is ignored.
  - Unmapped reads return 0; writes to RO or unmapped addresses are ignored.
- FSM states: IDLE, LOAD, RUN.
  - IDLE→LOAD: a write sets CTL[0] while it is 0. Load acc=START.
  - LOAD: one core per cycle, i=0..CORES-1. core_start_nonce[i]<=acc; acc<=acc+STRIDE, mod 2^NONCE_W. After CORES cycles go to RUN.
  - RUN: core_run all ones.
  - Any state→IDLE: CTL[0] written 0. core_run clears in the next cycle.
  - A write keeping CTL[0]=1 does not reload.
- Capture:
  - core_found sets pending[i] and latches the nonce.
  - A round-robin arbiter pushes one pending entry per cycle into the FIFO, starting after the last granted core.
  - Found on a core whose pending bit is already set: drop it and set overflow.
  - Push while the FIFO is full and no pop: drop and set overflow. Push and pop in the same cycle on a full FIFO succeeds.
- IRQ: pending sets on any push into an empty FIFO. irq = enable & (pending | overflow), registered.

## Timing
- Reset: all registers, readdata, irq, core_run, core_start_nonce, FSM (IDLE), acc, FIFO and pending bits cleared.
- readdata valid the cycle after read. A read of SOLN in the cycle before a pop returns the pre-pop head.
- Run write at cycle t: LOAD during t+1..t+CORES; core_run high at t+CORES+1.
- core_found at t: earliest FIFO entry at t+2; STAT[0] and irq at t+3.
- Reset asserted mid-LOAD or mid-RUN: core_run drops asynchronously and the FIFO empties.

## Structure
- Package miner_pkg holds:
  - register index and field-position localparams
  - the FSM state enum
  - the STAT/IRQ bit positions
- Sub-module miner_sol_fifo: synchronous FIFO of width NONCE_W+3, depth FIFO_DEPTH, with full, empty and level outputs.

## Test plan
- Reset, read 0, 1, 36 → "SHA3"; STAT[11:8]=4, [7:4]=8; SOLN_CORE=0.
- START=0xFFFF_FFFF_FFFF_FFFE, STRIDE=1, run → core starts FFFE, FFFF, 0, 1 (wrap); core_run high 5 cycles after the write.
- Cores 1 and 3 found in the same cycle → FIFO entries core 1 then core 3, with correct nonces. IRQ[1] set; irq=1 with enable. W1C clears it.
- 9 founds with FIFO_DEPTH=8 and no pops → level 8, overflow=1, 9th entry dropped. Pop all → entries 1–8 in order, then SOLN_CORE[31]=0.
- Pop coinciding with a push on a full FIFO → level stays 8, no overflow.
- Deassert rst_n mid-LOAD (cycle 2) → core_run=0, all core_start_nonce=0, STAT=CORES/STAGES fields only.

Source files
------------

// File: rtl/miner_pkg.sv
`default_nettype none
// ============================================================================
// miner_pkg : register map, field positions and FSM encodings for miner_csr_mc
// Revision  : 1.0
// ============================================================================
package miner_pkg;

    localparam logic [5:0] A_ID        = 6'd0;
    localparam logic [5:0] A_STAT      = 6'd1;
    localparam logic [5:0] A_CTL       = 6'd2;
    localparam logic [5:0] A_IRQ       = 6'd3;
    localparam logic [5:0] A_HDR       = 6'd4;
    localparam logic [5:0] A_DIFF      = 6'd12;
    localparam logic [5:0] A_START     = 6'd20;
    localparam logic [5:0] A_STRIDE    = 6'd24;
    localparam logic [5:0] A_SOLN      = 6'd32;
    localparam logic [5:0] A_SOLN_CORE = 6'd36;

    localparam logic [31:0] ID_VALUE = 32'h5348_4133;  // ASCII "SHA3"
    localparam logic [31:0] CTL_MASK = 32'hFFFF_0007;

    localparam int CTL_RUN  = 0;
    localparam int CTL_TEST = 1;
    localparam int CTL_HALT = 2;

    localparam int IRQ_EN   = 0;
    localparam int IRQ_PEND = 1;
    localparam int IRQ_OVF  = 2;

    localparam int STAT_NEMPTY     = 0;
    localparam int STAT_RUN        = 1;
    localparam int STAT_TEST       = 2;
    localparam int STAT_OVF        = 3;
    localparam int STAT_STAGES_LSB = 4;
    localparam int STAT_CORES_LSB  = 8;
    localparam int STAT_LEVEL_LSB  = 12;
    localparam int STAT_MAJ_LSB    = 24;
    localparam int STAT_MIN_LSB    = 28;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/miner_csr_mc_if.sv
`default_nettype none
// ============================================================================
// miner_csr_mc_if : Avalon-MM slave bus plus level interrupt
// Revision        : 1.0
// ============================================================================
interface miner_csr_mc_if;
    logic [5:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, read, write, writedata, input readdata, irq);
    modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface
`default_nettype wire

// File: rtl/miner_sol_fifo.sv
`default_nettype none
// ============================================================================
// miner_sol_fifo : synchronous solution FIFO, power-of-two depth, show-ahead head
// Revision       : 1.0
// ============================================================================
module miner_sol_fifo #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 8
) (
    input  wire                      clk,
    input  wire                      rst_n,
    input  wire                      push,
    input  wire  [WIDTH-1:0]         push_data,
    input  wire                      pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]                 lvl_q, lvl_d;
    logic                        w_do_push, w_do_pop;

    assign full      = lvl_q[AW];
    assign empty     = (lvl_q == '0);
    assign level     = lvl_q;
    assign head      = mem_q[rd_q];
    // a full FIFO still accepts a push when a pop frees the head slot in the same cycle
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (w_do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/miner_csr_mc.sv
`default_nettype none
// ============================================================================
// miner_csr_mc : Avalon-MM CSR block for a multi-core SHA3 miner array
// Revision     : 1.0
// ============================================================================
module miner_csr_mc
    import miner_pkg::*;
#(
    parameter int CORES      = 4,
    parameter int NONCE_W    = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int STAGES     = 8,
    parameter int MAJ_VER    = 0,
    parameter int MIN_VER    = 0
) (
    input  wire                         clk,
    input  wire                         rst_n,
    miner_csr_mc_if.slave               bus,
    output logic [255:0]                core_header,
    output logic [255:0]                core_difficulty,
    output logic [15:0]                 core_pad,
    output logic                        core_test,
    output logic                        core_halt,
    output logic [CORES-1:0]            core_run,
    output logic [CORES*NONCE_W-1:0]    core_start_nonce,
    input  wire  [CORES-1:0]            core_found,
    input  wire  [CORES*NONCE_W-1:0]    core_solution
);
    localparam int NW = NONCE_W / 32;
    localparam int FW = NONCE_W + 3;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]                  ctl_q, ctl_d, readdata_q, readdata_d;
    logic                         irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
    logic                         ovf_q, ovf_d, irq_q, irq_d;
    logic [7:0][31:0]             hdr_q, hdr_d, diff_q, diff_d;
    logic [NONCE_W-1:0]           start_q, start_d, stride_q, stride_d, acc_q, acc_d;
    state_t                       state_q, state_d;
    logic [2:0]                   load_idx_q, load_idx_d, last_q, last_d;
    logic [CORES-1:0]             run_q, run_d, pend_q, pend_d;
    logic [CORES*NONCE_W-1:0]     nonce_q, nonce_d;
    logic [CORES-1:0][NONCE_W-1:0] lat_q, lat_d;

    logic            w_wr_ctl, w_wr_irq, w_pop, w_gnt_valid, w_push_ok, w_ovf_set;
    logic [2:0]      w_gnt_idx;
    logic [FW-1:0]   w_push_data, w_head;
    logic            w_fifo_full, w_fifo_empty;
    logic [LW-1:0]   w_level;
    logic [31:0]     w_stat, w_rdata;
    logic [NONCE_W-1:0] w_head_nonce;
    int              cand;

    assign w_wr_ctl = bus.write && (bus.address == A_CTL);
    assign w_wr_irq = bus.write && (bus.address == A_IRQ);
    assign w_pop    = bus.write && (bus.address == A_SOLN_CORE);

    miner_sol_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push_ok),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .level     (w_level)
    );

    // Plain register writes
    always_comb begin
        ctl_d    = ctl_q;
        hdr_d    = hdr_q;
        diff_d   = diff_q;
        start_d  = start_q;
        stride_d = stride_q;
        if (w_wr_ctl) ctl_d = bus.writedata & CTL_MASK;
        for (int k = 0; k < 8; k++) begin
            if (bus.write && bus.address == 6'(A_HDR + k))  hdr_d[k]  = bus.writedata;
            if (bus.write && bus.address == 6'(A_DIFF + k)) diff_d[k] = bus.writedata;
        end
        for (int k = 0; k < NW; k++) begin
            if (bus.write && bus.address == 6'(A_START + k))
                start_d[(NW-1-k)*32 +: 32] = bus.writedata;
            if (bus.write && bus.address == 6'(A_STRIDE + k))
                stride_d[(NW-1-k)*32 +: 32] = bus.writedata;
        end
    end

    // Start-nonce distribution FSM
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        load_idx_d = load_idx_q;
        nonce_d    = nonce_q;
        run_d      = run_q;
        if (state_q == ST_LOAD) begin
            for (int i = 0; i < CORES; i++)
                if (load_idx_q == 3'(i)) nonce_d[i*NONCE_W +: NONCE_W] = acc_q;
            acc_d = acc_q + stride_q;
            if (load_idx_q == 3'(CORES-1)) begin
                state_d = ST_RUN;
                run_d   = '1;
            end else begin
                load_idx_d = load_idx_q + 3'd1;
            end
        end
        if (w_wr_ctl) begin
            if (bus.writedata[CTL_RUN] && !ctl_q[CTL_RUN]) begin
                state_d    = ST_LOAD;
                acc_d      = start_q;
                load_idx_d = '0;
            end else if (!bus.writedata[CTL_RUN]) begin
                state_d = ST_IDLE;
                run_d   = '0;
            end
        end
    end

    // Round-robin arbiter: search starts one past the last granted core
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_push_data = '0;
        cand        = 0;
        for (int k = 1; k <= CORES; k++) begin
            cand = int'(last_q) + k;
            if (cand >= CORES) cand = cand - CORES;
            for (int i = 0; i < CORES; i++) begin
                if (!w_gnt_valid && i == cand && pend_q[i]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = 3'(i);
                    w_push_data = {3'(i), lat_q[i]};
                end
            end
        end
    end

    assign w_push_ok = w_gnt_valid & (~w_fifo_full | w_pop);

    always_comb begin
        pend_d    = pend_q;
        lat_d     = lat_q;
        last_d    = last_q;
        w_ovf_set = 1'b0;
        for (int i = 0; i < CORES; i++) begin
            if (w_gnt_valid && w_gnt_idx == 3'(i)) pend_d[i] = 1'b0;
            if (core_found[i]) begin
                if (pend_q[i]) begin
                    w_ovf_set = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    lat_d[i]  = core_solution[i*NONCE_W +: NONCE_W];
                end
            end
        end
        if (w_gnt_valid) begin
            last_d = w_gnt_idx;
            if (!w_push_ok) w_ovf_set = 1'b1;
        end
    end

    // Set events take priority over a same-cycle W1C
    always_comb begin
        irq_en_d   = irq_en_q;
        irq_pend_d = irq_pend_q;
        ovf_d      = ovf_q;
        if (w_wr_irq) begin
            irq_en_d = bus.writedata[IRQ_EN];
            if (bus.writedata[IRQ_PEND]) irq_pend_d = 1'b0;
            if (bus.writedata[IRQ_OVF])  ovf_d      = 1'b0;
        end
        if (w_push_ok && w_fifo_empty) irq_pend_d = 1'b1;
        if (w_ovf_set)                 ovf_d      = 1'b1;
        irq_d = irq_en_q & (irq_pend_q | ovf_q);
    end

    assign w_head_nonce = w_fifo_empty ? '0 : w_head[NONCE_W-1:0];

    always_comb begin
        w_stat                          = '0;
        w_stat[STAT_NEMPTY]             = ~w_fifo_empty;
        w_stat[STAT_RUN]                = (state_q == ST_RUN);
        w_stat[STAT_TEST]               = ctl_q[CTL_TEST];
        w_stat[STAT_OVF]                = ovf_q;
        w_stat[STAT_STAGES_LSB +: 4]    = 4'(STAGES);
        w_stat[STAT_CORES_LSB +: 4]     = 4'(CORES);
        w_stat[STAT_LEVEL_LSB +: 5]     = 5'(w_level);
        w_stat[STAT_MAJ_LSB +: 4]       = 4'(MAJ_VER);
        w_stat[STAT_MIN_LSB +: 4]       = 4'(MIN_VER);

        w_rdata = '0;
        case (bus.address)
            A_ID:        w_rdata = ID_VALUE;
            A_STAT:      w_rdata = w_stat;
            A_CTL:       w_rdata = ctl_q;
            A_IRQ:       w_rdata = {29'd0, ovf_q, irq_pend_q, irq_en_q};
            A_SOLN_CORE: w_rdata = {~w_fifo_empty, 28'd0, w_fifo_empty ? 3'd0 : w_head[FW-1 -: 3]};
            default:     w_rdata = '0;
        endcase
        for (int k = 0; k < 8; k++) begin
            if (bus.address == 6'(A_HDR + k))  w_rdata = hdr_q[k];
            if (bus.address == 6'(A_DIFF + k)) w_rdata = diff_q[k];
        end
        for (int k = 0; k < NW; k++) begin
            if (bus.address == 6'(A_START + k))  w_rdata = start_q[(NW-1-k)*32 +: 32];
            if (bus.address == 6'(A_STRIDE + k)) w_rdata = stride_q[(NW-1-k)*32 +: 32];
            if (bus.address == 6'(A_SOLN + k))   w_rdata = w_head_nonce[(NW-1-k)*32 +: 32];
        end
        readdata_d = bus.read ? w_rdata : readdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q      <= '0;
            readdata_q <= '0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            hdr_q      <= '0;
            diff_q     <= '0;
            start_q    <= '0;
            stride_q   <= '0;
            acc_q      <= '0;
            state_q    <= ST_IDLE;
            load_idx_q <= '0;
            last_q     <= '0;
            run_q      <= '0;
            pend_q     <= '0;
            nonce_q    <= '0;
            lat_q      <= '0;
        end else begin
            ctl_q      <= ctl_d;
            readdata_q <= readdata_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            hdr_q      <= hdr_d;
            diff_q     <= diff_d;
            start_q    <= start_d;
            stride_q   <= stride_d;
            acc_q      <= acc_d;
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            last_q     <= last_d;
            run_q      <= run_d;
            pend_q     <= pend_d;
            nonce_q    <= nonce_d;
            lat_q      <= lat_d;
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_job_words
        assign core_header[(7-k)*32 +: 32]     = hdr_q[k];
        assign core_difficulty[(7-k)*32 +: 32] = diff_q[k];
    end

    assign core_pad         = ctl_q[31:16];
    assign core_test        = ctl_q[CTL_TEST];
    assign core_halt        = ctl_q[CTL_HALT];
    assign core_run         = run_q;
    assign core_start_nonce = nonce_q;
    assign bus.readdata     = readdata_q;
    assign bus.irq          = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_miner_csr_mc.sv
`default_nettype none
// ============================================================================
// tb_miner_csr_mc : directed register vectors plus job-load and solution-queue sequences
// Revision        : 1.0
// ============================================================================
module tb_miner_csr_mc;
    localparam int CORES = 4;
    localparam int NW    = 64;

    logic                  clk;
    logic                  rst_n;
    logic [CORES-1:0]      core_found;
    logic [CORES*NW-1:0]   core_solution;
    logic [255:0]          core_header, core_difficulty;
    logic [15:0]           core_pad;
    logic                  core_test, core_halt;
    logic [CORES-1:0]      core_run;
    logic [CORES*NW-1:0]   core_start_nonce;

    miner_csr_mc_if bus ();

    miner_csr_mc #(
        .CORES(CORES), .NONCE_W(NW), .FIFO_DEPTH(8), .STAGES(8), .MAJ_VER(0), .MIN_VER(0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .core_header      (core_header),
        .core_difficulty  (core_difficulty),
        .core_pad         (core_pad),
        .core_test        (core_test),
        .core_halt        (core_halt),
        .core_run         (core_run),
        .core_start_nonce (core_start_nonce),
        .core_found       (core_found),
        .core_solution    (core_solution)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [19];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.read    = 1'b1;
        @(negedge clk);
        bus.read    = 1'b0;
        d           = bus.readdata;
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, {224'd0, d}, {224'd0, exp});
    endtask

    initial begin
        logic [31:0] rd;
        int          c;

        rst_n         = 1'b0;
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        core_found    = '0;
        core_solution = '0;

        vecs[0]  = '{1'b0, 6'd0,  32'h0,         32'h5348_4133};
        vecs[1]  = '{1'b0, 6'd1,  32'h0,         32'h0000_0480};
        vecs[2]  = '{1'b0, 6'd36, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 6'd2,  32'h0,         32'h0};
        vecs[4]  = '{1'b0, 6'd3,  32'h0,         32'h0};
        vecs[5]  = '{1'b1, 6'd4,  32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{1'b0, 6'd4,  32'h0,         32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 6'd19, 32'h1234_5678, 32'h0};
        vecs[8]  = '{1'b0, 6'd19, 32'h0,         32'h1234_5678};
        vecs[9]  = '{1'b1, 6'd0,  32'h0,         32'h0};
        vecs[10] = '{1'b0, 6'd0,  32'h0,         32'h5348_4133};
        vecs[11] = '{1'b1, 6'd22, 32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{1'b0, 6'd22, 32'h0,         32'h0};
        vecs[13] = '{1'b0, 6'd40, 32'h0,         32'h0};
        vecs[14] = '{1'b1, 6'd21, 32'h0000_ABCD, 32'h0};
        vecs[15] = '{1'b0, 6'd21, 32'h0,         32'h0000_ABCD};
        vecs[16] = '{1'b1, 6'd2,  32'hA5A5_FFF6, 32'h0};
        vecs[17] = '{1'b0, 6'd2,  32'h0,         32'hA5A5_0006};
        vecs[18] = '{1'b0, 6'd1,  32'h0,         32'h0000_0484};

        repeat (3) @(negedge clk);
        check("reset_core_run", {252'd0, core_run}, 256'd0);
        check("reset_irq", {255'd0, bus.irq}, 256'd0);
        check("reset_readdata", {224'd0, bus.readdata}, 256'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            else            read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        check("hdr_word0", {224'd0, core_header[255:224]}, {224'd0, 32'hDEAD_BEEF});
        check("diff_word7", {224'd0, core_difficulty[31:0]}, {224'd0, 32'h1234_5678});
        check("ctl_outputs", {237'd0, core_pad, core_test, core_halt, 1'b0},
              {237'd0, 16'hA5A5, 1'b1, 1'b1, 1'b0});
        bus_write(6'd2, 32'h0);

        // Job load with wrapping start nonce
        bus_write(6'd20, 32'hFFFF_FFFF);
        bus_write(6'd21, 32'hFFFF_FFFE);
        bus_write(6'd24, 32'h0);
        bus_write(6'd25, 32'h1);
        bus_write(6'd2, 32'h1);
        check("load_run_t1", {252'd0, core_run}, 256'd0);
        repeat (3) begin
            @(negedge clk);
            check("load_run_low", {252'd0, core_run}, 256'd0);
        end
        @(negedge clk);
        check("load_run_high", {252'd0, core_run}, {252'd0, 4'hF});
        check("start_nonces", core_start_nonce,
              {64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});
        read_check("stat_run", 6'd1, 32'h0000_0482);
        bus_write(6'd21, 32'h0);
        bus_write(6'd2, 32'h1);
        repeat (6) @(negedge clk);
        check("no_reload", core_start_nonce[63:0], {192'd0, 64'hFFFF_FFFF_FFFF_FFFE});
        check("no_reload_run", {252'd0, core_run}, {252'd0, 4'hF});
        bus_write(6'd21, 32'hFFFF_FFFE);

        // Simultaneous finds on cores 1 and 3
        @(negedge clk);
        core_found = 4'b1010;
        core_solution[1*NW +: NW] = 64'h1111_0000_0000_0001;
        core_solution[3*NW +: NW] = 64'h3333_0000_0000_0003;
        @(negedge clk);
        core_found = '0;
        repeat (3) @(negedge clk);
        read_check("cap_stat", 6'd1, 32'h0000_2483);
        read_check("cap_soln_ms", 6'd32, 32'h1111_0000);
        read_check("cap_soln_ls", 6'd33, 32'h0000_0001);
        read_check("cap_core", 6'd36, 32'h8000_0001);
        read_check("cap_irq_reg", 6'd3, 32'h0000_0002);
        check("cap_irq_masked", {255'd0, bus.irq}, 256'd0);
        bus_write(6'd3, 32'h1);
        @(negedge clk);
        check("cap_irq_on", {255'd0, bus.irq}, {255'd0, 1'b1});
        bus_write(6'd36, 32'h0);
        read_check("cap2_soln_ms", 6'd32, 32'h3333_0000);
        read_check("cap2_core", 6'd36, 32'h8000_0003);
        bus_write(6'd36, 32'h0);
        read_check("cap_empty", 6'd36, 32'h0);
        bus_write(6'd3, 32'h3);
        @(negedge clk);
        check("w1c_irq_off", {255'd0, bus.irq}, 256'd0);
        read_check("w1c_irq_reg", 6'd3, 32'h0000_0001);

        bus_write(6'd2, 32'h0);
        check("stop_run", {252'd0, core_run}, 256'd0);

        // Nine finds, no pops: eight queued, ninth dropped with overflow
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("irq_timing%0d", k), {255'd0, bus.irq}, {255'd0, (k >= 3)});
            core_found    = 4'(1 << (k % 4));
            core_solution = '0;
            core_solution[(k % 4)*NW +: NW] = 64'(k + 1);
        end
        @(negedge clk);
        core_found = '0;
        repeat (3) @(negedge clk);
        read_check("ovf_stat", 6'd1, 32'h0000_8489);
        read_check("ovf_irq_reg", 6'd3, 32'h0000_0007);
        read_check("ovf_head_core", 6'd36, 32'h8000_0000);
        read_check("ovf_head_nonce", 6'd33, 32'h0000_0001);
        bus_write(6'd3, 32'h7);
        read_check("ovf_cleared", 6'd3, 32'h0000_0001);

        // Push coinciding with a pop on a full FIFO
        @(negedge clk);
        core_found = 4'b0010;
        core_solution = '0;
        core_solution[1*NW +: NW] = 64'h99;
        @(negedge clk);
        core_found    = '0;
        bus.address   = 6'd36;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write     = 1'b0;
        repeat (2) @(negedge clk);
        read_check("pp_stat", 6'd1, 32'h0000_8481);
        read_check("pp_irq_reg", 6'd3, 32'h0000_0001);
        for (int j = 0; j < 8; j++) begin
            read_check($sformatf("drain_nonce%0d", j), 6'd33, (j < 7) ? 32'(j + 2) : 32'h99);
            c = (j < 7) ? ((j + 1) % 4) : 1;
            read_check($sformatf("drain_core%0d", j), 6'd36, 32'h8000_0000 | 32'(c));
            bus_write(6'd36, 32'h0);
        end
        read_check("drain_empty", 6'd36, 32'h0);

        // Asynchronous reset while running with a queued solution
        bus_write(6'd2, 32'h1);
        repeat (5) @(negedge clk);
        check("rst_run_before", {252'd0, core_run}, {252'd0, 4'hF});
        core_found = 4'b0100;
        core_solution = '0;
        core_solution[2*NW +: NW] = 64'h77;
        @(negedge clk);
        core_found = '0;
        repeat (3) @(negedge clk);
        read_check("rst_stat_before", 6'd1, 32'h0000_1483);
        #2 rst_n = 1'b0;
        #1;
        check("rst_run_async", {252'd0, core_run}, 256'd0);
        check("rst_nonce_async", core_start_nonce, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("rst_stat_after", 6'd1, 32'h0000_0480);
        read_check("rst_fifo_after", 6'd36, 32'h0);
        read_check("rst_irq_after", 6'd3, 32'h0);

        // Asynchronous reset in the middle of LOAD
        bus_write(6'd21, 32'h5);
        bus_write(6'd25, 32'h10);
        bus_write(6'd2, 32'h1);
        @(negedge clk);
        check("midload_core0", core_start_nonce[63:0], {192'd0, 64'h5});
        @(negedge clk);
        check("midload_core1", core_start_nonce[127:64], {192'd0, 64'h15});
        #2 rst_n = 1'b0;
        #1;
        check("midload_rst_run", {252'd0, core_run}, 256'd0);
        check("midload_rst_nonce", core_start_nonce, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("midload_stat", 6'd1, 32'h0000_0480);
        repeat (6) @(negedge clk);
        check("midload_stays_idle", {252'd0, core_run}, 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
